// File: rtl/aoc_numdisp_pkg.sv
// aoc_numdisp_pkg: shared types and constants for the decimal display path
package aoc_numdisp_pkg;
    typedef enum logic [1:0] {IDLE, CONVERT, EMIT} state_t;
    localparam int DIGIT_W = 4;
    localparam int RADIX = 10;
    localparam logic [DIGIT_W-1:0] SIGN_CODE = 4'hF;
endpackage

// File: rtl/divmod10_unit.sv
// divmod10_unit: combinational unsigned divide and modulo by 10
//   i_in   [DATA_WIDTH-1:0] dividend
//   o_quot [DATA_WIDTH-1:0] i_in / 10
//   o_rem  [DIGIT_W-1:0]    i_in % 10, truncated to one BCD digit
module divmod10_unit
    import aoc_numdisp_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_in,
    output logic [DATA_WIDTH-1:0] o_quot,
    output logic [DIGIT_W-1:0]    o_rem
);
    assign o_quot = i_in / DATA_WIDTH'(RADIX);
    assign o_rem  = DIGIT_W'(i_in % DATA_WIDTH'(RADIX));
endmodule

// File: rtl/decimal_digit_sequencer.sv
// decimal_digit_sequencer: iterative signed-to-decimal converter streaming symbols MSD first
//   clk, rst            clock, asynchronous active-high reset
//   i_start_valid       value offered for conversion
//   o_start_ready       idle and able to accept a value
//   i_value             number to convert, sampled on the start handshake
//   o_busy              converting or emitting
//   o_digit_valid       output symbol valid
//   i_digit_ready       consumer accepts the symbol
//   o_digit             BCD digit or SIGN_CODE
//   o_digit_is_sign     current symbol is the minus sign
//   o_digit_last        final symbol of this number
module decimal_digit_sequencer
    import aoc_numdisp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DIGITS = 10,
    parameter bit SIGNED     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start_valid,
    output logic                  o_start_ready,
    input  logic [DATA_WIDTH-1:0] i_value,
    output logic                  o_busy,
    output logic                  o_digit_valid,
    input  logic                  i_digit_ready,
    output logic [DIGIT_W-1:0]    o_digit,
    output logic                  o_digit_is_sign,
    output logic                  o_digit_last
);
    localparam int IW = $clog2(NUM_DIGITS + 1);

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_mag, w_quot;
    logic [DIGIT_W-1:0]    r_slot [NUM_DIGITS];
    logic [DIGIT_W-1:0]    w_rem;
    logic [IW-1:0]         r_idx, r_ptr;
    logic                  r_sign;
    logic                  w_neg, w_start, w_xfer, w_conv_done, w_emit_done;

    divmod10_unit #(.DATA_WIDTH(DATA_WIDTH)) u_div (
        .i_in   (r_mag),
        .o_quot (w_quot),
        .o_rem  (w_rem)
    );

    assign w_neg       = SIGNED && i_value[DATA_WIDTH-1];
    assign w_start     = i_start_valid && o_start_ready;
    assign w_xfer      = o_digit_valid && i_digit_ready;
    assign w_conv_done = r_idx == IW'(NUM_DIGITS - 1);
    assign w_emit_done = w_xfer && o_digit_last;

    assign o_start_ready   = r_state == IDLE;
    assign o_busy          = r_state != IDLE;
    assign o_digit_valid   = r_state == EMIT;
    assign o_digit_is_sign = o_digit_valid && r_sign;
    assign o_digit_last    = o_digit_valid && !r_sign && r_ptr == '0;
    assign o_digit         = !o_digit_valid ? '0 : r_sign ? SIGN_CODE : r_slot[r_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? CONVERT : IDLE;
            CONVERT: w_next = w_conv_done ? EMIT : CONVERT;
            EMIT:    w_next = w_emit_done ? IDLE : EMIT;
            default: w_next = IDLE;
        endcase
    end

    // r_ptr tracks the most significant nonzero digit while converting,
    // then walks down to slot 0 as the emit pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mag  <= '0;
            r_idx  <= '0;
            r_ptr  <= '0;
            r_sign <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) r_slot[i] <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_start) begin
                    r_mag  <= w_neg ? ~i_value + 1'b1 : i_value;
                    r_sign <= w_neg;
                    r_idx  <= '0;
                    r_ptr  <= '0;
                end
                CONVERT: begin
                    r_slot[r_idx] <= w_rem;
                    r_mag         <= w_quot;
                    r_idx         <= r_idx + 1'b1;
                    if (w_rem != '0) r_ptr <= r_idx;
                end
                EMIT: if (w_xfer) begin
                    if (r_sign)            r_sign <= 1'b0;
                    else if (r_ptr != '0)  r_ptr  <= r_ptr - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
